// File: rtl/tri_raster_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tri_raster_scanner                                            |
// | Purpose  : Sequential triangle rasteriser. Latches one screen-space      |
// |            triangle per start, walks its scan rectangle in row-major     |
// |            order and streams per-pixel barycentric edge weights with an  |
// |            inside flag over a valid/ready interface. Edge functions are  |
// |            stepped with adds; multiplies happen only once, in SETUP.     |
// | Option   : TRI_RASTER_BBOX_EN - scan the clipped vertex bounding box     |
// |            instead of the full hRes x vRes screen.                       |
// | Ports    : clk, reset (async, active-high)                               |
// |            start, x_0..y_2        triangle request + signed vertices     |
// |            busy, done             progress / one-cycle completion pulse  |
// |            pix_valid, pix_ready   pixel stream handshake                 |
// |            pixX, pixY             current pixel coordinate               |
// |            w_0, w_1, w_2, area    winding-normalised weights, 2x area    |
// |            inTris                 pixel lies inside a non-degenerate tri |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tri_raster_scanner #(
  parameter int INT_BITS  = 10,
  parameter int EVAL_BITS = 10,
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  localparam int WB       = 2 * INT_BITS + 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic signed [INT_BITS:0]   x_0,
  input  logic signed [INT_BITS:0]   y_0,
  input  logic signed [INT_BITS:0]   x_1,
  input  logic signed [INT_BITS:0]   y_1,
  input  logic signed [INT_BITS:0]   x_2,
  input  logic signed [INT_BITS:0]   y_2,
  output logic                       busy,
  output logic                       done,
  output logic                       pix_valid,
  input  logic                       pix_ready,
  output logic [EVAL_BITS-1:0]       pixX,
  output logic [EVAL_BITS-1:0]       pixY,
  output logic signed [WB-1:0]       w_0,
  output logic signed [WB-1:0]       w_1,
  output logic signed [WB-1:0]       w_2,
  output logic signed [WB-1:0]       area,
  output logic                       inTris
);

  // Signed width able to hold both a vertex coordinate and a screen bound.
  localparam int CW = ((INT_BITS > EVAL_BITS) ? INT_BITS : EVAL_BITS) + 2;
  localparam logic signed [CW-1:0] C_H_MAX = CW'(H_RES - 1);
  localparam logic signed [CW-1:0] C_V_MAX = CW'(V_RES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t r_state;

  logic signed [INT_BITS:0] r_vx [3];
  logic signed [INT_BITS:0] r_vy [3];
  logic signed [WB-1:0]     r_w   [3];  // weights at the current pixel
  logic signed [WB-1:0]     r_row [3];  // weights at the left edge of the current row
  logic signed [WB-1:0]     r_dx  [3];
  logic signed [WB-1:0]     r_dy  [3];
  logic [EVAL_BITS-1:0]     r_x_lo;
  logic [EVAL_BITS-1:0]     r_x_hi;
  logic [EVAL_BITS-1:0]     r_y_hi;

  function automatic logic signed [WB-1:0] edge_fn(
    input logic signed [WB-1:0] ax, input logic signed [WB-1:0] ay,
    input logic signed [WB-1:0] bx, input logic signed [WB-1:0] by,
    input logic signed [WB-1:0] px, input logic signed [WB-1:0] py);
    edge_fn = (bx - ax) * (py - ay) - (by - ay) * (px - ax);
  endfunction

  // ---------------------------------------------------------------- scan rect
  logic signed [CW-1:0] w_lo_x, w_hi_x, w_lo_y, w_hi_y;
  logic                 w_rect_empty;

`ifdef TRI_RASTER_BBOX_EN
  function automatic logic signed [CW-1:0] min3(
    input logic signed [CW-1:0] a, input logic signed [CW-1:0] b,
    input logic signed [CW-1:0] c);
    logic signed [CW-1:0] m;
    m = (a < b) ? a : b;
    min3 = (c < m) ? c : m;
  endfunction

  function automatic logic signed [CW-1:0] max3(
    input logic signed [CW-1:0] a, input logic signed [CW-1:0] b,
    input logic signed [CW-1:0] c);
    logic signed [CW-1:0] m;
    m = (a > b) ? a : b;
    max3 = (c > m) ? c : m;
  endfunction

  logic signed [CW-1:0] w_min_x, w_max_x, w_min_y, w_max_y;

  always_comb begin
    w_min_x = min3(CW'(r_vx[0]), CW'(r_vx[1]), CW'(r_vx[2]));
    w_max_x = max3(CW'(r_vx[0]), CW'(r_vx[1]), CW'(r_vx[2]));
    w_min_y = min3(CW'(r_vy[0]), CW'(r_vy[1]), CW'(r_vy[2]));
    w_max_y = max3(CW'(r_vy[0]), CW'(r_vy[1]), CW'(r_vy[2]));
    // Box entirely left/above (max < 0) or right/below (min > bound).
    w_rect_empty = w_max_x[CW-1] || w_max_y[CW-1] ||
                   (w_min_x > C_H_MAX) || (w_min_y > C_V_MAX);
    w_lo_x = w_min_x[CW-1] ? '0 : w_min_x;
    w_lo_y = w_min_y[CW-1] ? '0 : w_min_y;
    w_hi_x = (w_max_x > C_H_MAX) ? C_H_MAX : w_max_x;
    w_hi_y = (w_max_y > C_V_MAX) ? C_V_MAX : w_max_y;
  end
`else
  always_comb begin
    w_rect_empty = 1'b0;
    w_lo_x       = '0;
    w_lo_y       = '0;
    w_hi_x       = C_H_MAX;
    w_hi_y       = C_V_MAX;
  end
`endif

  // ------------------------------------------------------------ setup math
  logic signed [WB-1:0] w_ex [3];
  logic signed [WB-1:0] w_ey [3];
  logic signed [WB-1:0] w_raw_w  [3];
  logic signed [WB-1:0] w_raw_dx [3];
  logic signed [WB-1:0] w_raw_dy [3];
  logic signed [WB-1:0] w_init [3];
  logic signed [WB-1:0] w_dx   [3];
  logic signed [WB-1:0] w_dy   [3];
  logic signed [WB-1:0] w_px, w_py, w_raw_area, w_area;
  logic                 w_flip;
  logic                 w_init_in;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_ex[i] = WB'(r_vx[i]);
      w_ey[i] = WB'(r_vy[i]);
    end
    w_px       = WB'(w_lo_x);
    w_py       = WB'(w_lo_y);
    w_raw_area = edge_fn(w_ex[0], w_ey[0], w_ex[1], w_ey[1], w_ex[2], w_ey[2]);
    w_flip     = w_raw_area[WB-1];
    w_area     = w_flip ? -w_raw_area : w_raw_area;

    // w_i = edge(v_j, v_k, p): x-step is (a.y - b.y), y-step is (b.x - a.x).
    w_raw_w[0]  = edge_fn(w_ex[1], w_ey[1], w_ex[2], w_ey[2], w_px, w_py);
    w_raw_w[1]  = edge_fn(w_ex[2], w_ey[2], w_ex[0], w_ey[0], w_px, w_py);
    w_raw_w[2]  = edge_fn(w_ex[0], w_ey[0], w_ex[1], w_ey[1], w_px, w_py);
    w_raw_dx[0] = w_ey[1] - w_ey[2];
    w_raw_dy[0] = w_ex[2] - w_ex[1];
    w_raw_dx[1] = w_ey[2] - w_ey[0];
    w_raw_dy[1] = w_ex[0] - w_ex[2];
    w_raw_dx[2] = w_ey[0] - w_ey[1];
    w_raw_dy[2] = w_ex[1] - w_ex[0];

    // Clockwise triangles are flipped once here so the scan loop never sees sign.
    for (int i = 0; i < 3; i++) begin
      w_init[i] = w_flip ? -w_raw_w[i]  : w_raw_w[i];
      w_dx[i]   = w_flip ? -w_raw_dx[i] : w_raw_dx[i];
      w_dy[i]   = w_flip ? -w_raw_dy[i] : w_raw_dy[i];
    end
    w_init_in = (w_area != '0) && !w_init[0][WB-1] &&
                !w_init[1][WB-1] && !w_init[2][WB-1];
  end

  // ------------------------------------------------------------- scan step
  logic signed [WB-1:0] w_next [3];
  logic                 w_at_x_end;
  logic                 w_last;
  logic                 w_next_in;

  always_comb begin
    w_at_x_end = (pixX == r_x_hi);
    w_last     = w_at_x_end && (pixY == r_y_hi);
    for (int i = 0; i < 3; i++) begin
      w_next[i] = w_at_x_end ? (r_row[i] + r_dy[i]) : (r_w[i] + r_dx[i]);
    end
    // Area is non-zero whenever SCAN is reached, so only the signs matter.
    w_next_in = !w_next[0][WB-1] && !w_next[1][WB-1] && !w_next[2][WB-1];
  end

  // -------------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pix_valid <= 1'b0;
      pixX      <= '0;
      pixY      <= '0;
      area      <= '0;
      inTris    <= 1'b0;
      r_x_lo    <= '0;
      r_x_hi    <= '0;
      r_y_hi    <= '0;
      for (int i = 0; i < 3; i++) begin
        r_vx[i]  <= '0;
        r_vy[i]  <= '0;
        r_w[i]   <= '0;
        r_row[i] <= '0;
        r_dx[i]  <= '0;
        r_dy[i]  <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_vx[0] <= x_0;
            r_vy[0] <= y_0;
            r_vx[1] <= x_1;
            r_vy[1] <= y_1;
            r_vx[2] <= x_2;
            r_vy[2] <= y_2;
            busy    <= 1'b1;
            r_state <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          area   <= w_area;
          inTris <= w_init_in;
          pixX   <= EVAL_BITS'(w_lo_x);
          pixY   <= EVAL_BITS'(w_lo_y);
          r_x_lo <= EVAL_BITS'(w_lo_x);
          r_x_hi <= EVAL_BITS'(w_hi_x);
          r_y_hi <= EVAL_BITS'(w_hi_y);
          for (int i = 0; i < 3; i++) begin
            r_w[i]   <= w_init[i];
            r_row[i] <= w_init[i];
            r_dx[i]  <= w_dx[i];
            r_dy[i]  <= w_dy[i];
          end
          if ((w_area == '0) || w_rect_empty) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            pix_valid <= 1'b1;
            r_state   <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          // pix_valid is always high in this state.
          if (pix_ready) begin
            if (w_last) begin
              pix_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              r_state   <= ST_DONE;
            end else begin
              inTris <= w_next_in;
              for (int i = 0; i < 3; i++) begin
                r_w[i] <= w_next[i];
              end
              if (w_at_x_end) begin
                pixX <= r_x_lo;
                pixY <= pixY + EVAL_BITS'(1);
                for (int i = 0; i < 3; i++) begin
                  r_row[i] <= w_next[i];
                end
              end else begin
                pixX <= pixX + EVAL_BITS'(1);
              end
            end
          end
        end

        ST_DONE: begin
          done    <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_0 = r_w[0];
  assign w_1 = r_w[1];
  assign w_2 = r_w[2];

endmodule
`default_nettype wire

// File: tb/tb_tri_raster_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_tri_raster_scanner                                         |
// | Purpose  : Directed self-checking bench for tri_raster_scanner on a      |
// |            reduced 32x24 screen. Expected weights come from a direct     |
// |            multiply-based edge function plus hand-computed constants.   |
// |            Follows TRI_RASTER_BBOX_EN for the expected scan rectangle.  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_tri_raster_scanner;

  localparam int IB = 10;
  localparam int EB = 10;
  localparam int HR = 32;
  localparam int VR = 24;
  localparam int WB = 2 * IB + 5;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                start = 1'b0;
  logic signed [IB:0]  x_0 = '0, y_0 = '0, x_1 = '0, y_1 = '0, x_2 = '0, y_2 = '0;
  logic                busy, done, pix_valid;
  logic                pix_ready = 1'b1;
  logic [EB-1:0]       pixX, pixY;
  logic signed [WB-1:0] w_0, w_1, w_2, area;
  logic                inTris;

  int checks   = 0;
  int failures = 0;
  int vx [3];
  int vy [3];
  logic signed [WB-1:0] cap_w0 [HR][VR];
  logic signed [WB-1:0] cap_w1 [HR][VR];
  logic signed [WB-1:0] cap_w2 [HR][VR];
  logic                 cap_in [HR][VR];

  tri_raster_scanner #(
    .INT_BITS (IB),
    .EVAL_BITS(EB),
    .H_RES    (HR),
    .V_RES    (VR)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .x_0      (x_0),
    .y_0      (y_0),
    .x_1      (x_1),
    .y_1      (y_1),
    .x_2      (x_2),
    .y_2      (y_2),
    .busy     (busy),
    .done     (done),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pixX     (pixX),
    .pixY     (pixY),
    .w_0      (w_0),
    .w_1      (w_1),
    .w_2      (w_2),
    .area     (area),
    .inTris   (inTris)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint ef(input longint ax, input longint ay, input longint bx,
                                input longint by, input longint px, input longint py);
    return (bx - ax) * (py - ay) - (by - ay) * (px - ax);
  endfunction

  // Accept a triangle; returns at the negedge inside the SETUP cycle.
  task automatic start_tri(input int ax, input int ay, input int bx, input int by,
                           input int cx, input int cy);
    @(negedge clk);
    vx[0] = ax; vy[0] = ay; vx[1] = bx; vy[1] = by; vx[2] = cx; vy[2] = cy;
    x_0 = 11'(ax); y_0 = 11'(ay); x_1 = 11'(bx); y_1 = 11'(by);
    x_2 = 11'(cx); y_2 = 11'(cy);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("setup_busy", busy, 1);
    chk("setup_valid", pix_valid, 0);
  endtask

  // Consume the pixel stream until done, checking order, weights and timing.
  task automatic scan_tri(input int x_lo, input int x_hi, input int y_lo, input int y_hi,
                          input int stall_x, input int stall_y,
                          output int n_pix, output int n_in);
    int ex, ey, stall_left;
    bit got_done, prev_last_hs, expect_pix;
    longint sg, m0, m1, m2;
    logic signed [WB-1:0] h0, h1, h2;
    ex = x_lo; ey = y_lo; n_pix = 0; n_in = 0; stall_left = 3;
    got_done = 0; prev_last_hs = 0;
    h0 = '0; h1 = '0; h2 = '0;
    expect_pix = (x_hi >= x_lo) && (y_hi >= y_lo);
    sg = (ef(vx[0], vy[0], vx[1], vy[1], vx[2], vy[2]) < 0) ? -1 : 1;
    for (int g = 0; g < 2000 && !got_done; g++) begin
      @(negedge clk);
      if (g == 0) begin
        chk("first_valid", pix_valid, expect_pix);
        chk("first_done", done, !expect_pix);
      end
      if (done) begin
        got_done = 1;
        chk("done_after_last", prev_last_hs, expect_pix);
        chk("busy_with_done", busy, 0);
        chk("valid_with_done", pix_valid, 0);
      end else if (pix_valid) begin
        prev_last_hs = 0;
        if (pixX == EB'(stall_x) && pixY == EB'(stall_y) && stall_left > 0) begin
          if (stall_left == 3) begin
            h0 = w_0; h1 = w_1; h2 = w_2;
          end else begin
            chk("hold_x", pixX, stall_x);
            chk("hold_y", pixY, stall_y);
            chk("hold_w0", w_0, h0);
            chk("hold_w1", w_1, h1);
            chk("hold_w2", w_2, h2);
          end
          pix_ready = 1'b0;
          stall_left--;
        end else begin
          pix_ready = 1'b1;
          m0 = sg * ef(vx[1], vy[1], vx[2], vy[2], ex, ey);
          m1 = sg * ef(vx[2], vy[2], vx[0], vy[0], ex, ey);
          m2 = sg * ef(vx[0], vy[0], vx[1], vy[1], ex, ey);
          chk("pix_x", pixX, ex);
          chk("pix_y", pixY, ey);
          chk("w0", w_0, m0);
          chk("w1", w_1, m1);
          chk("w2", w_2, m2);
          chk("in_tris", inTris, (m0 >= 0 && m1 >= 0 && m2 >= 0));
          if (pixX < EB'(HR) && pixY < EB'(VR)) begin
            cap_w0[pixX][pixY] = w_0;
            cap_w1[pixX][pixY] = w_1;
            cap_w2[pixX][pixY] = w_2;
            cap_in[pixX][pixY] = inTris;
          end
          n_pix++;
          n_in += int'(inTris);
          prev_last_hs = (ex == x_hi) && (ey == y_hi);
          ex++;
          if (ex > x_hi) begin
            ex = x_lo;
            ey++;
          end
        end
      end
    end
    pix_ready = 1'b1;
    chk("done_seen", got_done, 1);
    chk("pix_count", n_pix, expect_pix ? (x_hi - x_lo + 1) * (y_hi - y_lo + 1) : 0);
    @(negedge clk);
    chk("done_pulse_width", done, 0);
  endtask

  initial begin
    int np, ni;
    int t_xl, t_xh, t_yl, t_yh, o_xl, o_xh, o_yl, o_yh;
`ifdef TRI_RASTER_BBOX_EN
    t_xl = 10; t_xh = 20; t_yl = 10; t_yh = 20;
    o_xl = 0;  o_xh = -1; o_yl = 0;  o_yh = -1;
`else
    t_xl = 0;  t_xh = HR - 1; t_yl = 0; t_yh = VR - 1;
    o_xl = 0;  o_xh = HR - 1; o_yl = 0; o_yh = VR - 1;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", pix_valid, 0);
    chk("rst_pixx", pixX, 0);
    chk("rst_pixy", pixY, 0);
    chk("rst_w0", w_0, 0);
    chk("rst_area", area, 0);
    chk("rst_intris", inTris, 0);
    reset = 1'b0;

    // Counter-clockwise triangle with a 3-cycle stall at (12,10)
    start_tri(10, 10, 20, 10, 10, 20);
    scan_tri(t_xl, t_xh, t_yl, t_yh, 12, 10, np, ni);
    chk("t1_area", area, 100);
    chk("t1_in_count", ni, 66);
    chk("t1_w0_10_10", cap_w0[10][10], 100);
    chk("t1_w1_10_10", cap_w1[10][10], 0);
    chk("t1_w2_10_10", cap_w2[10][10], 0);
    chk("t1_in_10_10", cap_in[10][10], 1);
    chk("t1_w0_15_15", cap_w0[15][15], 0);
    chk("t1_w1_15_15", cap_w1[15][15], 50);
    chk("t1_w2_15_15", cap_w2[15][15], 50);
    chk("t1_in_15_15", cap_in[15][15], 1);
    chk("t1_w0_16_16", cap_w0[16][16], -20);
    chk("t1_in_16_16", cap_in[16][16], 0);
    chk("t1_w1_12_14", cap_w1[12][14], 20);
    chk("t1_w2_12_14", cap_w2[12][14], 40);

    // Same triangle, clockwise winding
    start_tri(10, 10, 10, 20, 20, 10);
    scan_tri(t_xl, t_xh, t_yl, t_yh, -1, -1, np, ni);
    chk("t2_area", area, 100);
    chk("t2_in_count", ni, 66);
    chk("t2_w0_10_10", cap_w0[10][10], 100);
    chk("t2_w0_12_14", cap_w0[12][14], 40);
    chk("t2_w1_12_14", cap_w1[12][14], 40);
    chk("t2_w2_12_14", cap_w2[12][14], 20);

    // Collinear vertices: zero area, no pixels, done at N+2
    start_tri(0, 0, 5, 5, 10, 10);
    scan_tri(0, -1, 0, -1, -1, -1, np, ni);
    chk("col_area", area, 0);

    // Triangle entirely left of the screen
    start_tri(-50, 5, -10, 5, -30, 20);
    scan_tri(o_xl, o_xh, o_yl, o_yh, -1, -1, np, ni);
    chk("off_in_count", ni, 0);
    chk("off_area", area, 600);

    // Reset in the middle of a scan, then a fresh triangle
    start_tri(10, 10, 20, 10, 10, 20);
    repeat (6) @(negedge clk);
    chk("pre_abort_valid", pix_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("abort_valid", pix_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_pixx", pixX, 0);
    chk("abort_pixy", pixY, 0);
    chk("abort_w0", w_0, 0);
    chk("abort_w1", w_1, 0);
    chk("abort_area", area, 0);
    chk("abort_intris", inTris, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
    end
    start_tri(10, 10, 10, 20, 20, 10);
    scan_tri(t_xl, t_xh, t_yl, t_yh, -1, -1, np, ni);
    chk("t3_in_count", ni, 66);
    chk("t3_area", area, 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tri_raster_scanner.md
# tri_raster_scanner

Sequential triangle rasteriser that accepts one screen-space triangle per start handshake, walks pixels in raster order and streams per-pixel barycentric edge weights with an inside flag. Edge functions are evaluated incrementally, with adds per step rather than multiplies per pixel. Output is a valid/ready stream. It sits between the triangle setup stage and the pixel shading/framebuffer writer, and generalises the per-pixel barycentric evaluator: a parametrised resolution, its own scan counter, winding normalisation and flow control.

## Interface
- intBits, 10: vertex coordinates are signed, intBits+1 bits two's complement.
- evalBits, 10: pixel coordinate width (unsigned).
- hRes, 640: screen width in pixels; x scans 0..hRes-1.
- vRes, 480: screen height in pixels; y scans 0..vRes-1.
- Derived WB = 2*intBits+5: signed width of weights and area.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- x_0, y_0, x_1, y_1, x_2, y_2  in  intBits+1 each  signed vertices; latched on accepted start.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle pulse when the triangle is finished.
- pix_valid  out  1  pixel output valid.
- pix_ready  in  1  downstream accepts the pixel.
- pixX, pixY  out  evalBits each  current pixel.
- w_0, w_1, w_2  out  WB each  signed edge weights, winding-normalised.
- area  out  WB  signed 2x triangle area, always >= 0.
- inTris  out  1  w_0>=0 && w_1>=0 && w_2>=0 and area != 0.

## Operation
- Edge function: edge(a,b,p) = (b.x-a.x)*(p.y-a.y) - (b.y-a.y)*(p.x-a.x).
  - w_0 = edge(v1,v2,p), w_1 = edge(v2,v0,p), w_2 = edge(v0,v1,p), rawArea = edge(v0,v1,v2).
  - Invariant: w_0 + w_1 + w_2 == area.
- Winding normalisation: if rawArea < 0, negate rawArea and all three weights (negate once at setup; increments are negated too).
- All arithmetic is exact at WB bits. There is no saturation or truncation.
- FSM states:
  - IDLE: a start in this state latches the vertices and moves to SETUP.
  - SETUP, one cycle: compute the scan rectangle, rawArea, the step increments dX_i and dY_i, and w_i at the first pixel.
    - If area == 0 or the rectangle is empty, go to DONE.
    - Otherwise go to SCAN.
  - SCAN: present a pixel. On pix_valid && pix_ready, advance x.
    - At the rectangle's right edge, x returns to its left edge, y increments, and the weights reload from the row-start register plus dY_i.
    - A handshake on the last pixel goes to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- start outside IDLE is ignored.
- Scan order is row-major: x fastest, then y.
- Each pixel is emitted exactly once, whether inside or outside.

## Timing
- Reset (asynchronous) forces IDLE and clears busy, done, pix_valid, pixX, pixY, w_0..w_2, area and inTris to 0.
  - Reset mid-SCAN abandons the triangle immediately. No done pulse is issued.
- start sampled at edge N:
  - SETUP occupies N+1.
  - pix_valid=1 from N+2.
- Throughput is 1 pixel/clock while pix_ready=1.
- While pix_valid=1 && pix_ready=0, all pixel outputs hold stable.
- pix_valid never drops without a handshake except on reset.
- done is asserted the cycle after the last handshake. busy falls together with done.
- The earliest next start is accepted the cycle after done.
- Degenerate or empty triangle: done at N+2, no pix_valid.
- area is valid from SETUP until the next accepted start.

## Configuration
- TRI_RASTER_BBOX_EN defined:
  - The scan rectangle is the vertex bounding box clipped to [0,hRes-1] x [0,vRes-1].
  - A bounding box entirely off-screen yields zero pixels.
- Not defined:
  - The scan rectangle is the full screen, hRes*vRes pixels per triangle.
  - Weights and inTris are computed identically.
  - The off-screen-triangle case emits all pixels with inTris=0.

## Test plan
- v0=(10,10), v1=(20,10), v2=(10,20), BBOX_EN, pix_ready=1 -> expected response:
  - area=100.
  - 121 pixels from (10,10) to (20,20).
  - (10,10): w=(100,0,0), inTris=1.
  - (15,15): w=(0,50,50), inTris=1.
  - (16,16): w_0=-20, inTris=0.
  - 66 pixels with inTris=1.
  - done one cycle after pixel (20,20).
- Same triangle with v1 and v2 swapped -> expected response:
  - area=100.
  - inTris count 66.
  - w_0 at (10,10) = 100.
  - w_1 and w_2 swapped relative to the first case.
- Backpressure: drop pix_ready for 3 cycles while pixel (12,10) is presented -> expected response:
  - pixX=12, pixY=10 and weights held.
  - Next handshake yields (13,10).
  - No pixel lost or duplicated.
- Collinear vertices (0,0), (5,5), (10,10) -> expected response:
  - area=0.
  - No pix_valid.
  - done at start+2.
- Triangle with all vertices at x in -50..-10 and BBOX_EN -> zero pixels and done. Same triangle without BBOX_EN -> 307200 pixels, all with inTris=0.
- Reset asserted mid-scan, then a new start -> expected response:
  - Outputs zero asynchronously.
  - No done pulse for the aborted triangle.
  - Second triangle scans from its first pixel correctly.
